// File: rtl/rr_arb2_if.sv
// Request/grant bundle between two requesters and the rr_arb2 arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants and mux select.
interface rr_arb2_if;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;
    logic sw;

    modport master (
        output req_a, req_b,
        input  gnt_a, gnt_b, sel, busy, sw
    );

    modport slave (
        input  req_a, req_b,
        output gnt_a, gnt_b, sel, busy, sw
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with registered grants, mux select and switch pulse.
// Define RR_ARB2_BURST_LIMIT_EN to compile in the BURST_MAX consecutive-grant limiter.
module rr_arb2 #(
    parameter int unsigned BURST_MAX = 4
) (
    input logic       clk,
    input logic       rst,
    rr_arb2_if.slave  bus
);

    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("rr_arb2: BURST_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntA = 2'd1,
        StGntB = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   sw_q, sw_d;
    logic   last_q, last_d;  // 0: A granted last, 1: B granted last
    logic   enter;
    logic   limit_hit;

`ifdef RR_ARB2_BURST_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;

    assign limit_hit = (cnt_q == 8'(BURST_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (enter) begin
            cnt_d = 8'd1;
        end else if (state_q != StIdle && state_d == state_q && !limit_hit) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_a && bus.req_b) begin
                    state_d = last_q ? StGntA : StGntB;
                end else if (bus.req_a) begin
                    state_d = StGntA;
                end else if (bus.req_b) begin
                    state_d = StGntB;
                end
            end
            StGntA: begin
                if (bus.req_a) begin
                    if (limit_hit && bus.req_b) state_d = StGntB;
                end else if (bus.req_b) begin
                    state_d = StGntB;
                end else begin
                    state_d = StIdle;
                end
            end
            StGntB: begin
                if (bus.req_b) begin
                    if (limit_hit && bus.req_a) state_d = StGntA;
                end else if (bus.req_a) begin
                    state_d = StGntA;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Any entry into a grant state, from idle or from the other grant.
    assign enter = (state_d != StIdle) && (state_d != state_q);

    always_comb begin
        sel_d  = sel_q;
        last_d = last_q;
        sw_d   = enter;
        if (state_d == StGntA) sel_d = 1'b0;
        if (state_d == StGntB) sel_d = 1'b1;
        if (enter) last_d = (state_d == StGntB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            sw_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sw_q    <= sw_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt_a = (state_q == StGntA);
    assign bus.gnt_b = (state_q == StGntB);
    assign bus.sel   = sel_q;
    assign bus.busy  = (state_q == StGntA) || (state_q == StGntB);
    assign bus.sw    = sw_q;

endmodule

// File: tb/tb_rr_arb2.sv
// Directed bench for rr_arb2: each step queues its expected outputs, then pops and checks
// {gnt_a, gnt_b, sel, busy, sw} one time unit after the clock edge.
module tb_rr_arb2;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    logic [4:0] exp_q[$];

    rr_arb2_if bus ();

    rr_arb2 #(
        .BURST_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [4:0] obs;
        logic [4:0] e;
        obs = {bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.sw};
        e   = exp_q.pop_front();
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s: got %b expected %b (gnt_a gnt_b sel busy sw)", tag, obs, e);
    endtask

    task automatic step(input logic r, input logic ra, input logic rb, input logic [4:0] e,
                        input string tag);
        rst       = r;
        bus.req_a = ra;
        bus.req_b = rb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        logic [4:0] e;
        int pos;
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;

        // Reset dominates requests.
        step(1, 1, 1, 5'b00000, "reset_1");
        step(1, 1, 1, 5'b00000, "reset_2");

        // Single request, 1-cycle latency, sw pulses once.
        step(0, 1, 0, 5'b10011, "a_grant");
        step(0, 1, 0, 5'b10010, "a_hold");

        // Handover without idle bubble, then idle keeps sel.
        step(0, 0, 1, 5'b01111, "a_to_b");
        step(0, 0, 0, 5'b00100, "idle_sel_hold");

        // Contention after serving B goes to A, and vice versa.
        step(0, 1, 1, 5'b10011, "rr_after_b");
        step(0, 0, 0, 5'b00000, "idle_after_a");
        step(0, 1, 1, 5'b01111, "rr_after_a");
        step(0, 0, 1, 5'b01110, "b_hold");

        // Reset mid-grant, then A wins first contention.
        step(1, 1, 1, 5'b00000, "reset_mid_grant");
        step(0, 1, 1, 5'b10011, "post_reset_a");

        // Continuous contention: limiter rotates every 4 cycles, otherwise A keeps it.
        for (int i = 0; i < 12; i++) begin
`ifdef RR_ARB2_BURST_LIMIT_EN
            pos = (i + 1) % 8;
            e   = (pos < 4) ? 5'b10010 : 5'b01110;
            e[0] = (pos % 4 == 0);
`else
            pos = i;
            e   = 5'b10010;
`endif
            step(0, 1, 1, e, $sformatf("contend_%0d", pos));
        end

        // Limit reached with no competitor: grant is held.
        step(1, 0, 0, 5'b00000, "reset_again");
        step(0, 1, 0, 5'b10011, "solo_a");
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 5'b10010, "solo_a_hold");
        end
        step(0, 0, 0, 5'b00000, "solo_a_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL timeout: bench did not complete, got running expected finished");
    end

endmodule
